sobel_gradient: RTL and testbench
=================================

SOBEL_GRADIENT -- requirements
Module: sobel_gradient

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64, pixels per row (>=3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 64, rows per frame (>=3).
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 pixel_in  input  8  unsigned grayscale pixel, row-major raster order.
REQ-006 pixel_valid  input  1  pixel_in accepted on this edge when high; no backpressure.
REQ-007 frame_start  input  1  qualified by pixel_valid; marks pixel (row 0, col 0).
REQ-008 gx_out  output  11  signed two's-complement horizontal Sobel gradient.
REQ-009 gy_out  output  11  signed two's-complement vertical Sobel gradient.
REQ-010 grad_valid  output  1  gx_out/gy_out hold a valid interior-window result this cycle.
REQ-011 frame_done  output  1  one-cycle pulse coincident with the last grad_valid of a frame.

Function
REQ-012 SHALL keep column and row counters of the accepted pixel; both advance only on pixel_valid; column wraps IMG_WIDTH-1->0 and increments row; row wraps IMG_HEIGHT-1->0.
REQ-013 frame_start with pixel_valid SHALL force the accepted pixel to (0,0) regardless of counter state, abandoning any partial frame; in-flight pipeline results of the old frame still emerge.
REQ-014 SHALL hold two line buffers of IMG_WIDTH pixels delaying the stream by one and two rows, plus a 3x3 window shift register; all shift only on pixel_valid.
REQ-015 Window p[r][c], r,c in 0..2, r=0 oldest row, c=0 oldest column; p[2][2] is the newest pixel.
REQ-016 gx = (p[0][2] + 2p[1][2] + p[2][2]) - (p[0][0] + 2p[1][0] + p[2][0]).
REQ-017 gy = (p[2][0] + 2p[2][1] + p[2][2]) - (p[0][0] + 2p[0][1] + p[0][2]).
REQ-018 Arithmetic SHALL be 11-bit signed; range -1020..+1020; no saturation or overflow possible.
REQ-019 A result SHALL be produced only for accepted pixels with row>=2 and col>=2; (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame, row-major; border pixels produce none.
REQ-020 Latency: pixel accepted at edge N (completing a window) -> grad_valid high, with its gx_out/gy_out, in the cycle after edge N+1; pipeline is two register stages (window, output).
REQ-021 The output stage SHALL advance every cycle; grad_valid is high for exactly one cycle per result; gaps in pixel_valid produce gaps in grad_valid, never duplicates.
REQ-022 gx_out/gy_out SHALL hold their last value while grad_valid is low.
REQ-023 frame_done SHALL assert with the result for the accepted pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-024 Line buffer contents after frame wrap are stale but unused, because REQ-019 gating restarts at row 2.

Reset
REQ-025 On n_rst low: counters, window, gx_out, gy_out SHALL be 0; grad_valid and frame_done 0; line buffer contents need not be cleared.
REQ-026 Reset mid-frame SHALL discard all in-flight results; the first accepted pixel after release is (0,0) with or without frame_start.

Structure
REQ-027 Package sobel_pkg SHALL hold IMG_WIDTH/IMG_HEIGHT defaults, typedef pixel_t (8-bit unsigned), grad_t (11-bit signed).
REQ-028 Sub-module line_buffer (depth IMG_WIDTH, 8-bit, shift-on-enable) SHALL be instantiated twice.
REQ-029 gx_out/gy_out SHALL connect directly to the downstream magnitude/threshold stage, which is purely combinational.

Verification (IMG_WIDTH=IMG_HEIGHT=8)
REQ-030 Uniform frame of 100 -> 36 grad_valid pulses, all gx=gy=0, frame_done with the 36th.
REQ-031 Columns 0-3 = 0, 4-7 = 255 -> windows spanning cols 3..4 (accepted col 4 and 5) give gx=+1020 and +1020... windows at col 3..5 boundary: centre col 3 gx=+1020, centre col 4 gx=+1020, others 0; gy=0 everywhere.
REQ-032 Rows 0-3 = 0, rows 4-7 = 255 -> gy=+1020 for window centre rows 3 and 4, gx=0; inverted image gives gy=-1020 (0x404).
REQ-033 Random pixels with pixel_valid deasserted on random cycles -> result sequence identical to gap-free run; grad_valid exactly 2 edges after each qualifying accept.
REQ-034 n_rst pulsed after 20 pixels, then a full frame -> no results from the aborted frame; 36 correct results; frame_start at pixel 30 of a frame -> counters restart, next frame's 36 results correct.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel gradient datapath.
package sobel_pkg;

  localparam int IMG_WIDTH_DEF  = 64;
  localparam int IMG_HEIGHT_DEF = 64;

  // Unsigned grayscale sample.
  typedef logic [7:0] pixel_t;

  // Signed gradient; |g| <= 4*255 = 1020 fits in 11 bits.
  typedef logic signed [10:0] grad_t;

endpackage

// File: rtl/sobel_gradient_line_buffer.sv
// One-row delay line: a shift register of DEPTH pixels that advances on enable.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF
) (
  input  logic   clk,
  input  logic   i_en,
  input  pixel_t i_din,
  output pixel_t o_dout
);

  pixel_t r_mem [DEPTH];

  // Shift one sample per accepted pixel; storage is data only, so no reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  // The oldest entry is the pixel exactly DEPTH accepts ago.
  assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/sobel_gradient.sv
// 3x3 Sobel gradient: raster position counters, two line buffers, a window
// register stage and a registered gx/gy output stage.
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  input  logic        frame_start,
  output logic signed [10:0] gx_out,
  output logic signed [10:0] gy_out,
  output logic        grad_valid,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // Zero-extend a pixel into the signed gradient width.
  function automatic grad_t ext(input pixel_t p);
    return grad_t'({3'b000, p});
  endfunction

  // (a + 2b + c) - (d + 2e + f); operands are bounded so no saturation needed.
  function automatic grad_t kernel(input pixel_t a, input pixel_t b, input pixel_t c,
                                   input pixel_t d, input pixel_t e, input pixel_t f);
    grad_t pos;
    grad_t neg;
    pos = ext(a) + (ext(b) <<< 1) + ext(c);
    neg = ext(d) + (ext(e) <<< 1) + ext(f);
    return pos - neg;
  endfunction

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_qual;
  logic          w_last;
  pixel_t        w_lb0_out;
  pixel_t        w_lb1_out;
  pixel_t        r_win_p0 [3][3];
  logic          r_vld_p0;
  logic          r_last_p0;
  grad_t         w_gx;
  grad_t         w_gy;
  grad_t         r_gx_p1;
  grad_t         r_gy_p1;
  logic          r_vld_p1;
  logic          r_done_p1;

  // Position of the pixel being accepted; frame_start pins it to (0,0).
  always_comb begin
    w_col  = frame_start ? '0 : r_col;
    w_row  = frame_start ? '0 : r_row;
    w_qual = pixel_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
    w_last = w_qual && (w_row == ROW_LAST) && (w_col == COL_LAST);
  end

  // Raster counters advance past the accepted pixel, wrapping column then row.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pixel_valid) begin
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk    (clk),
    .i_en   (pixel_valid),
    .i_din  (pixel_in),
    .o_dout (w_lb0_out)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk    (clk),
    .i_en   (pixel_valid),
    .i_din  (w_lb0_out),
    .o_dout (w_lb1_out)
  );

  // ---- stage p0: 3x3 window (row 2 = newest row, column 2 = newest column) ----
  // Shift the window left and load the new column from the stream and line buffers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win_p0[r][c] <= '0;
        end
      end
    end else if (pixel_valid) begin
      for (int r = 0; r < 3; r++) begin
        r_win_p0[r][0] <= r_win_p0[r][1];
        r_win_p0[r][1] <= r_win_p0[r][2];
      end
      r_win_p0[0][2] <= w_lb1_out;
      r_win_p0[1][2] <= w_lb0_out;
      r_win_p0[2][2] <= pixel_in;
    end
  end

  // Window qualifiers are re-evaluated every cycle so a gap never repeats a result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
    end else begin
      r_vld_p0  <= w_qual;
      r_last_p0 <= w_last;
    end
  end

  assign w_gx = kernel(r_win_p0[0][2], r_win_p0[1][2], r_win_p0[2][2],
                       r_win_p0[0][0], r_win_p0[1][0], r_win_p0[2][0]);
  assign w_gy = kernel(r_win_p0[2][0], r_win_p0[2][1], r_win_p0[2][2],
                       r_win_p0[0][0], r_win_p0[0][1], r_win_p0[0][2]);

  // ---- stage p1: registered gradients, held between valid results ----
  // Capture gradients only for qualifying windows; flags advance every cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_gx_p1   <= '0;
      r_gy_p1   <= '0;
      r_vld_p1  <= 1'b0;
      r_done_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= r_vld_p0;
      r_done_p1 <= r_last_p0;
      if (r_vld_p0) begin
        r_gx_p1 <= w_gx;
        r_gy_p1 <= w_gy;
      end
    end
  end

  assign gx_out     = r_gx_p1;
  assign gy_out     = r_gy_p1;
  assign grad_valid = r_vld_p1;
  assign frame_done = r_done_p1;

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed bench for sobel_gradient on an 8x8 image with hand-derived gradients.
module tb_sobel_gradient;

  logic               clk = 1'b0;
  logic               n_rst;
  logic [7:0]         pixel_in;
  logic               pixel_valid;
  logic               frame_start;
  logic signed [10:0] gx_out;
  logic signed [10:0] gy_out;
  logic               grad_valid;
  logic               frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected-result slot for the pixel accepted on the previous edge.
  integer s_vld, s_gx, s_gy, s_done;
  integer last_gx, last_gy;
  int     row, col;
  int     results, dones;

  sobel_gradient #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .gx_out      (gx_out),
    .gy_out      (gy_out),
    .grad_valid  (grad_valid),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input integer got, input integer want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Patterns: 0 uniform 100, 1 vertical edge, 2 horizontal edge,
  // 3 inverted horizontal edge, 4 ramp 3*col + 10*row.
  function automatic logic [7:0] pix_of(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'd100;
      1:       return (c >= 4) ? 8'd255 : 8'd0;
      2:       return (r >= 4) ? 8'd255 : 8'd0;
      3:       return (r >= 4) ? 8'd0 : 8'd255;
      default: return 8'(3 * c + 10 * r);
    endcase
  endfunction

  // Hand-derived gradients for the accepted (bottom-right) window pixel.
  function automatic integer gx_of(input int pat, input int r, input int c);
    if (pat == 1) return (c == 4 || c == 5) ? 1020 : 0;
    if (pat == 4) return 24;
    return 0;
  endfunction

  function automatic integer gy_of(input int pat, input int r, input int c);
    if (pat == 2) return (r == 4 || r == 5) ? 1020 : 0;
    if (pat == 3) return (r == 4 || r == 5) ? -1020 : 0;
    if (pat == 4) return 80;
    return 0;
  endfunction

  // One clock: drive, take the edge, check the previous accept, record this one.
  task automatic tick(input int pat, input logic v, input logic fs);
    if (v && fs) begin
      row = 0;
      col = 0;
    end
    pixel_in    = v ? pix_of(pat, row, col) : 8'hA5;
    pixel_valid = v;
    frame_start = fs;
    @(posedge clk);
    #1;
    check("grad_valid", grad_valid, s_vld);
    if (s_vld == 1) begin
      check("gx", gx_out, s_gx);
      check("gy", gy_out, s_gy);
      check("frame_done", frame_done, s_done);
      last_gx = s_gx;
      last_gy = s_gy;
      results++;
      if (s_done == 1) dones++;
    end else begin
      check("gx_hold", gx_out, last_gx);
      check("gy_hold", gy_out, last_gy);
      check("frame_done_idle", frame_done, 0);
    end
    s_vld  = 0;
    s_done = 0;
    if (v) begin
      if (row >= 2 && col >= 2) begin
        s_vld  = 1;
        s_gx   = gx_of(pat, row, col);
        s_gy   = gy_of(pat, row, col);
        s_done = (row == 7 && col == 7) ? 1 : 0;
      end
      if (col == 7) begin
        col = 0;
        row = (row == 7) ? 0 : row + 1;
      end else begin
        col = col + 1;
      end
    end
  endtask

  task automatic send(input int pat, input int npix, input logic fs, input logic gaps);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) tick(pat, 1'b0, 1'b0);
      if (gaps && $urandom_range(0, 4) == 0) tick(pat, 1'b0, 1'b0);
      tick(pat, 1'b1, fs && (i == 0));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(0, 1'b0, 1'b0);
  endtask

  task automatic reset_model();
    s_vld = 0; s_gx = 0; s_gy = 0; s_done = 0;
    last_gx = 0; last_gy = 0;
    row = 0; col = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_gx", gx_out, 0);
    check("rst_gy", gy_out, 0);
    check("rst_valid", grad_valid, 0);
    check("rst_done", frame_done, 0);
  endtask

  initial begin
    n_rst = 1'b0;
    pixel_in = 8'd0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    reset_model();
    results = 0;
    dones = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    n_rst = 1'b1;

    // Uniform frame: 36 zero results, frame_done on the last.
    results = 0; dones = 0;
    send(0, 64, 1'b1, 1'b0);
    drain(3);
    check("uniform_count", results, 36);
    check("uniform_done", dones, 1);

    // Vertical edge: gx = +1020 at accepted cols 4 and 5.
    results = 0; dones = 0;
    send(1, 64, 1'b1, 1'b0);
    drain(3);
    check("vedge_count", results, 36);

    // Horizontal edge and its inverse.
    results = 0; dones = 0;
    send(2, 64, 1'b1, 1'b0);
    send(3, 64, 1'b1, 1'b0);
    drain(3);
    check("hedge_count", results, 72);
    check("hedge_done", dones, 2);

    // Ramp with random input gaps: constant gx=24, gy=80, no duplicates.
    results = 0; dones = 0;
    send(4, 64, 1'b1, 1'b1);
    drain(3);
    check("gap_count", results, 36);
    check("gap_done", dones, 1);

    // Reset after 20 pixels: nothing of that frame may appear afterwards.
    send(4, 20, 1'b1, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_outputs();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    n_rst = 1'b1;
    results = 0; dones = 0;
    send(1, 64, 1'b0, 1'b0);
    drain(3);
    check("post_reset_count", results, 36);
    check("post_reset_done", dones, 1);

    // frame_start after 30 pixels: 10 in-flight results, then a full frame.
    results = 0; dones = 0;
    send(0, 30, 1'b1, 1'b0);
    send(2, 64, 1'b1, 1'b0);
    drain(3);
    check("restart_count", results, 46);
    check("restart_done", dones, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
